mix_round_sched: RTL
====================

# mix_round_sched

Scheduler and arbiter that shares one iterative 8×32-bit mixing core between two requesters. It grants the core to one requester at a time in round-robin order and pulses the core's load strobe so the core takes that requester's seed. It then issues exactly the requested number of round steps, gated by the core's ready signal, and acknowledges the requester when the last round has been applied. It sits between the requesting clients and the mixing core; the core's datapath (state registers, round arithmetic, seed/result muxing) lives outside this block.

## Interface
- CNT_W, 8: width of the round-count inputs and of core_round.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-requester request level; must stay high, with its rounds value stable, until ack.
- rounds0  in  CNT_W  requested round count for requester 0.
- rounds1  in  CNT_W  requested round count for requester 1.
- core_ready  in  1  core can accept a round step this cycle.
- grant  out  2  one-hot; the owner of the core, held from LOAD through DONE.
- ack  out  2  one-cycle pulse to the owner in DONE; the core result is valid in that cycle.
- core_load  out  1  one-cycle pulse in LOAD; the core loads the seed of core_sel.
- core_step  out  1  the core applies one round this cycle.
- core_sel  out  1  index of the current owner.
- core_round  out  CNT_W  0-based index of the round being stepped.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- State machine: IDLE, LOAD, RUN, DONE. All outputs are registered state decodes, except core_step, which equals (state==RUN) & core_ready.
- IDLE:
  - req is sampled only in this state.
  - If any req bit is high: pick the owner, latch sel and the selected rounds into remaining, clear core_round, go to LOAD.
  - If req is 0, stay in IDLE.
- Arbitration:
  - With a single request, that requester wins.
  - With both requesting, the winner is the requester that is not last_grant.
  - last_grant updates to sel on leaving DONE.
  - Reset value of last_grant is 1, so requester 0 wins the first contention.
- LOAD: core_load=1 and grant[sel]=1.
  - If remaining==0, go to DONE; no core_step is ever issued.
  - Otherwise go to RUN.
- RUN: on each cycle with core_step=1:
  - remaining decrements and core_round increments.
  - If remaining was 1, go to DONE.
  - With core_ready=0, hold all state; no step is issued.
- DONE: ack[sel]=1 for one cycle, grant held, then go to IDLE.
- Arithmetic: remaining and core_round are CNT_W-bit unsigned.
  - Maximum rounds is 2^CNT_W−1.
  - core_round never wraps, because it stops at rounds−1.
- Changes to req or rounds while busy are ignored.
- A req still high in the IDLE cycle after ack is treated as a new request.

## Timing
- Reset (rst=1 at an edge): state=IDLE, last_grant=1, remaining=0. grant, ack, core_load, core_sel, core_round and busy are all 0; core_step is 0.
- Reset mid-operation aborts the job at the next edge: no ack is issued, and the core is left in whatever partial state it had.
- Latency with core_ready held high, for a request seen at edge k:
  - LOAD during cycle k+1.
  - Steps during cycles k+2 .. k+1+R.
  - ack during cycle k+2+R.
  - IDLE in cycle k+3+R.
  - R=0 gives ack in cycle k+2.
- Each core_ready=0 cycle in RUN adds exactly one cycle of latency.
- Minimum spacing between consecutive grants is R+3 cycles.
- Requesters must drop req by the edge that ends the ack cycle; a registered response to ack satisfies this.

## Test plan
- Single request, R=5:
  - Stimulus: req=01, rounds0=5, core_ready=1.
  - Required response: core_load in cycle 1; core_step in cycles 2–6 with core_round 0..4; ack=01 in cycle 7; busy high in cycles 1–7.
- Contention:
  - Stimulus: req=11 held, rounds0=2, rounds1=3.
  - Required response: grant order is 0, 1, 0, 1, strictly alternating; each job issues its exact step count.
- Back-pressure:
  - Stimulus: R=4, core_ready low for 3 cycles mid-RUN.
  - Required response: exactly 4 core_step pulses; ack arrives 3 cycles late; core_round holds during the stall.
- Zero rounds:
  - Stimulus: rounds1=0, req=10.
  - Required response: LOAD then ack=10 in the next cycle; core_step is never asserted.
- Reset mid-RUN:
  - Stimulus: assert rst after the 2nd of 6 steps.
  - Required response: all outputs 0 at the next edge; no ack; a subsequent req=11 is granted to requester 0.
- Maximum count:
  - Stimulus: rounds0=255 (CNT_W=8).
  - Required response: 255 steps; core_round ends at 254; no wrap occurs.

Source files
------------

// File: rtl/mix_round_sched.sv
// Round-robin scheduler for a shared iterative mixing core: grants the core to one
// of two requesters, strobes the seed load, issues the requested round steps and acks.
module mix_round_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] rounds0,
    input  logic [CNT_W-1:0] rounds1,
    input  logic             core_ready,
    output logic [1:0]       grant,
    output logic [1:0]       ack,
    output logic             core_load,
    output logic             core_step,
    output logic             core_sel,
    output logic [CNT_W-1:0] core_round,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic             sel_r;
    logic             last_grant_r;
    logic [CNT_W-1:0] remaining_r;
    logic             win_s;
    logic [CNT_W-1:0] win_rounds_s;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Arbitration: a lone requester wins; under contention the one not served last wins
    always_comb begin
        win_s        = 1'b0;
        win_rounds_s = rounds0;
        if (req == 2'b11) begin
            win_s = ~last_grant_r;
        end else begin
            win_s = req[1];
        end
        if (win_s) begin
            win_rounds_s = rounds1;
        end else begin
            win_rounds_s = rounds0;
        end
    end

    // Step is the one combinational output so a ready core is never left idle a cycle
    assign core_step = (state_r == RUN) & core_ready;

    // Scheduler FSM with registered state-decoded outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            sel_r        <= 1'b0;
            last_grant_r <= 1'b1;
            remaining_r  <= {CNT_W{1'b0}};
            grant        <= 2'b00;
            ack          <= 2'b00;
            core_load    <= 1'b0;
            core_sel     <= 1'b0;
            core_round   <= {CNT_W{1'b0}};
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req != 2'b00) begin
                        state_r     <= LOAD;
                        sel_r       <= win_s;
                        remaining_r <= win_rounds_s;
                        core_round  <= {CNT_W{1'b0}};
                        grant       <= onehot(win_s);
                        core_sel    <= win_s;
                        core_load   <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    core_load <= 1'b0;
                    if (remaining_r == {CNT_W{1'b0}}) begin
                        state_r <= DONE;
                        ack     <= onehot(sel_r);
                    end else begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (core_ready) begin
                        remaining_r <= remaining_r - CNT_W'(1);
                        // The last step leaves core_round at rounds-1 so it can never wrap
                        if (remaining_r == CNT_W'(1)) begin
                            state_r <= DONE;
                            ack     <= onehot(sel_r);
                        end else begin
                            core_round <= core_round + CNT_W'(1);
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    last_grant_r <= sel_r;
                    ack          <= 2'b00;
                    grant        <= 2'b00;
                    core_sel     <= 1'b0;
                    busy         <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    ack       <= 2'b00;
                    grant     <= 2'b00;
                    core_load <= 1'b0;
                    core_sel  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
